// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: drives the ROM from the fetch PC and queues words for decode.
// Define IFU_WFI_HALT_EN to stop fetching after a WFI word is enqueued.
module instr_fetch_unit #(
  parameter int unsigned L        = 32,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned RESET_PC = 0,
  localparam int unsigned AW      = $clog2(L)
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [AW-1:0] rom_addr,
  output logic          rom_oe,
  input  logic [31:0]   rom_data,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_pc,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic [31:0]   instr,
  output logic [AW-1:0] instr_pc,
  output logic          halted
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] fpc_q, fpc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   data_q [DEPTH];
  logic [AW-1:0] pc_q   [DEPTH];

  logic empty, full, pop, push, fetch_en;

`ifdef IFU_WFI_HALT_EN
  localparam logic [31:0] WfiWord = 32'h1050_0073;

  typedef enum logic [0:0] {StFetch, StHalt} state_e;
  state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = StFetch;
    end else if (push && (rom_data == WfiWord)) begin
      state_d = StHalt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  assign fetch_en = (state_q == StFetch);
  assign halted   = (state_q == StHalt);
`else
  assign fetch_en = 1'b1;
  assign halted   = 1'b0;
`endif

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign pop   = ~empty & instr_ready;
  // A full queue may still accept a word when the head leaves in the same cycle.
  assign push  = fetch_en & (~full | pop) & ~redirect_valid;

  assign rom_oe      = push & rst_n;
  assign rom_addr    = fpc_q;
  assign instr_valid = ~empty;
  assign instr       = empty ? '0 : data_q[rd_ptr_q];
  assign instr_pc    = empty ? '0 : pc_q[rd_ptr_q];

  always_comb begin
    fpc_d    = fpc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect_valid) begin
      fpc_d    = redirect_pc;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        fpc_d    = (fpc_q == AW'(L - 1)) ? '0 : fpc_q + 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fpc_q    <= AW'(RESET_PC);
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      fpc_q    <= fpc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Queue storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk) begin
    if (push && rst_n) begin
      data_q[wr_ptr_q] <= rom_data;
      pc_q[wr_ptr_q]   <= fpc_q;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: vector table, directed corner cases and
// randomized traffic against a queue-based reference model.
module tb_instr_fetch_unit;

  localparam int L = 32;
  localparam int DEPTH = 2;
  localparam int AW = 5;
  localparam logic [31:0] WFI = 32'h1050_0073;
`ifdef IFU_WFI_HALT_EN
  localparam bit HaltEn = 1'b1;
`else
  localparam bit HaltEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] rom_addr;
  logic          rom_oe;
  logic [31:0]   rom_data;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic [31:0]   instr;
  logic [AW-1:0] instr_pc;
  logic          halted;

  logic [31:0] rom [L];
  assign rom_data = rom[rom_addr];

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .L(L),
    .DEPTH(DEPTH),
    .RESET_PC(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rom_addr(rom_addr),
    .rom_oe(rom_oe),
    .rom_data(rom_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .instr_pc(instr_pc),
    .halted(halted)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: queue of fetched words, fetch PC and halt flag.
  logic [31:0] mq_data[$];
  int          mq_pc[$];
  int          m_fpc;
  bit          m_halt;

  typedef struct {
    bit rst;
    bit rdy;
    int ev;
    int epc;
    int eoe;
    int eaddr;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, compare against the model, then advance the model.
  task automatic apply(input bit r, input bit rdy, input bit rv, input int rpc);
    bit pop, push;
    logic [31:0] w;
    rst_n = r;
    instr_ready = rdy;
    redirect_valid = rv;
    redirect_pc = AW'(rpc);
    #2;
    chk("m_valid", {31'd0, instr_valid}, {31'd0, mq_pc.size() > 0});
    if (mq_pc.size() > 0) begin
      chk("m_pc", {27'd0, instr_pc}, mq_pc[0]);
      chk("m_instr", instr, mq_data[0]);
    end
    chk("m_addr", {27'd0, rom_addr}, m_fpc);
    chk("m_halted", {31'd0, halted}, {31'd0, m_halt});
    pop = (mq_pc.size() > 0) && rdy;
    push = !m_halt && ((mq_pc.size() < DEPTH) || pop) && !rv;
    chk("m_oe", {31'd0, rom_oe}, {31'd0, push && r});
    if (!r) begin
      mq_data.delete();
      mq_pc.delete();
      m_fpc = 0;
      m_halt = 0;
    end else if (rv) begin
      mq_data.delete();
      mq_pc.delete();
      m_fpc = rpc;
      m_halt = 0;
    end else begin
      if (pop) begin
        void'(mq_data.pop_front());
        void'(mq_pc.pop_front());
      end
      if (push) begin
        w = rom[m_fpc];
        mq_data.push_back(w);
        mq_pc.push_back(m_fpc);
        if (HaltEn && w == WFI) m_halt = 1;
        m_fpc = (m_fpc + 1) % L;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t tbl[$];
    bit seen;

    tbl.push_back('{0, 1, 0, 0, 0, 0});
    tbl.push_back('{1, 1, 0, 0, 1, 0});
    tbl.push_back('{1, 1, 1, 0, 1, 1});
    tbl.push_back('{1, 1, 1, 1, 1, 2});
    tbl.push_back('{1, 1, 1, 2, 1, 3});
    tbl.push_back('{1, 1, 1, 3, 1, 4});
    tbl.push_back('{0, 0, 1, 4, 0, 5});
    tbl.push_back('{1, 0, 0, 0, 1, 0});
    tbl.push_back('{1, 0, 1, 0, 1, 1});
    tbl.push_back('{1, 0, 1, 0, 0, 2});
    tbl.push_back('{1, 0, 1, 0, 0, 2});
    tbl.push_back('{1, 1, 1, 0, 1, 2});
    tbl.push_back('{1, 1, 1, 1, 1, 3});
    tbl.push_back('{1, 1, 1, 2, 1, 4});
    tbl.push_back('{1, 1, 1, 3, 1, 5});

    rom[0] = 32'h0000_0093;
    rom[1] = 32'h0010_0113;
    rom[2] = 32'h0000_2183;
    rom[3] = 32'h0010_8093;
    rom[4] = 32'h0031_13E3;
    for (int i = 5; i < 11; i++) rom[i] = 32'h0000_0013;
    for (int i = 11; i < L; i++) rom[i] = WFI;

    rst_n = 1'b0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    m_fpc = 0;
    m_halt = 0;

    // Reset release with ready high, then ready-low backpressure.
    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].rst, tbl[i].rdy, 1'b0, 0);
      chk($sformatf("v%0d_valid", i), {31'd0, instr_valid}, tbl[i].ev);
      if (tbl[i].ev != 0) begin
        chk($sformatf("v%0d_pc", i), {27'd0, instr_pc}, tbl[i].epc);
        chk($sformatf("v%0d_instr", i), instr, rom[tbl[i].epc]);
      end
      chk($sformatf("v%0d_oe", i), {31'd0, rom_oe}, tbl[i].eoe);
      chk($sformatf("v%0d_addr", i), {27'd0, rom_addr}, tbl[i].eaddr);
      chk($sformatf("v%0d_halted", i), {31'd0, halted}, 0);
      tick();
    end

    // Redirect with queue holding pc 5,6 and a coincident pop.
    apply(1, 1, 0, 0); tick();
    apply(1, 1, 1, 4);
    chk("t3_head", {27'd0, instr_pc}, 5);
    tick();
    apply(1, 1, 0, 0);
    chk("t3_valid0", {31'd0, instr_valid}, 0);
    chk("t3_addr", {27'd0, rom_addr}, 4);
    tick();
    apply(1, 1, 0, 0);
    chk("t3_pc4", {27'd0, instr_pc}, 4);
    chk("t3_bne", instr, 32'h0031_13E3);
    tick();

    // Free-run up to the WFI word.
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      apply(1, 1, 0, 0);
      if (instr_valid && instr_pc == 11) begin
        seen = 1;
        chk("t4_wfi", instr, WFI);
        chk("t4_halted", {31'd0, halted}, {31'd0, HaltEn});
      end
      tick();
    end
    chk("t4_reach", {31'd0, seen}, 1);
    for (int i = 0; i < 4; i++) begin
      apply(1, 1, 0, 0);
      chk("t4_valid", {31'd0, instr_valid}, {31'd0, !HaltEn});
      chk("t4_oe", {31'd0, rom_oe}, {31'd0, !HaltEn});
      chk("t4_hold", {31'd0, halted}, {31'd0, HaltEn});
      tick();
    end
    apply(1, 1, 1, 0); tick();
    apply(1, 1, 0, 0);
    chk("t4_resume_halt", {31'd0, halted}, 0);
    chk("t4_resume_addr", {27'd0, rom_addr}, 0);
    tick();
    apply(1, 1, 0, 0);
    chk("t4_resume_pc", {27'd0, instr_pc}, 0);
    tick();

    // Address wrap from L-1 to 0.
    rom[31] = 32'h0000_0013;
    apply(1, 1, 1, 31); tick();
    apply(1, 1, 0, 0);
    chk("t5_addr", {27'd0, rom_addr}, 31);
    tick();
    for (int i = 0; i < 3; i++) begin
      apply(1, 1, 0, 0);
      chk("t5_pc", {27'd0, instr_pc}, (31 + i) % L);
      tick();
    end

    // Reset with a full queue (halted too when WFI halting is built).
    apply(1, 0, 1, 10); tick();
    apply(1, 0, 0, 0); tick();
    apply(1, 0, 0, 0); tick();
    apply(1, 0, 0, 0);
    chk("t6_full_oe", {31'd0, rom_oe}, 0);
    chk("t6_halted", {31'd0, halted}, {31'd0, HaltEn});
    tick();
    apply(0, 0, 0, 0); tick();
    apply(1, 0, 0, 0);
    chk("t6_valid", {31'd0, instr_valid}, 0);
    chk("t6_oe", {31'd0, rom_oe}, 1);
    chk("t6_addr", {27'd0, rom_addr}, 0);
    chk("t6_halted0", {31'd0, halted}, 0);
    tick();

    // Randomized traffic against the model.
    for (int i = 0; i < 500; i++) begin
      apply($urandom_range(63) != 0, $urandom_range(3) != 0, $urandom_range(15) == 0,
            int'($urandom_range(L - 1)));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
